instruction_encoder: RTL
========================

// Module: instruction_encoder
// PURPOSE
//  Encodes MIPS instructions from field-level requests (kind, rs, rt, rd, shamt, imm, target) into 32-bit words.
//  Writes each word sequentially into instruction memory starting at BASE_ADDR.
//  Acts as the program loader: tests and boot logic build code here, and the decoder consumes it.
//  Covers the same instruction subset the datapath decodes: sll, or, add, addi, andi, sw, lw, beq, bne, j.
// PARAMETERS
//  ADDR_W     32            width of mem_addr (byte address)
//  BASE_ADDR  32'h00400000  byte address of the first word written
//  DEPTH      64            maximum words written before full
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       request valid
//  in_ready     out  1       encoder can accept; =1 only in IDLE
//  op_sel       in   4       0 sll,1 or,2 add,3 addi,4 andi,5 sw,6 lw,7 beq,8 bne,9 j; 10-15 illegal
//  rs,rt,rd     in   5 each  register fields
//  shamt        in   5       shift amount (sll only)
//  imm          in   16      immediate/offset (I type)
//  target       in   26      jump target (j only)
//  clear        in   1       restart at BASE_ADDR; honoured in IDLE/FULL only
//  mem_we       out  1       write strobe to instruction memory
//  mem_addr     out  ADDR_W  byte address of current/next write
//  mem_wdata    out  32      encoded instruction word
//  mem_ack      in   1       memory accepted write this cycle
//  err_illegal  out  1       1-cycle pulse: illegal op_sel accepted, nothing written
//  full         out  1       DEPTH words written
//  word_count   out  $clog2(DEPTH+1)  words written since reset/clear
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_illegal=0, full=0, word_count=0.
//  FSM states: IDLE, WRITE, FULL.
//  IDLE: a request is accepted on in_valid&in_ready in cycle N.
//   - Legal op: mem_wdata is registered at N. At N+1 the FSM enters WRITE and mem_we=1.
//   - Illegal op: err_illegal=1 at N+1 only. The FSM stays in IDLE; no write, no address change.
//  WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ack=1.
//   - On the ack cycle: mem_addr+=4 and word_count+=1.
//   - The FSM moves to FULL if the new word_count==DEPTH, otherwise to IDLE; mem_we=0 from the next cycle.
//  FULL: full=1, in_ready=0, mem_we=0. Only clear or reset exits.
//  clear in IDLE/FULL: next cycle mem_addr=BASE_ADDR, word_count=0, full=0, state=IDLE.
//  clear has priority over a same-cycle in_valid, and that request is not accepted.
//  clear in WRITE is ignored; the write completes normally.
//  reset mid-WRITE aborts the write; mem_we drops the next cycle and all outputs take reset values.
//  Encoding ({} = MSB..LSB); unused fields are 0:
//   R: {6'h00, rs, rt, rd, shamt, funct}; sll funct 6'h00 (rs forced 0), or 6'h25, add 6'h20; shamt forced 0 for or/add.
//   I: {opc, rs, rt, imm}; addi 6'h08, andi 6'h0C, sw 6'h2B, lw 6'h23, beq 6'h04, bne 6'h05.
//   J: {6'h02, target}.
//  mem_addr always increments by 4; it never wraps, because FULL blocks further writes.
// TESTING
//  T1: after reset, add rs=1,rt=2,rd=3 -> mem_we at N+1, addr 0x00400000, data 0x00221820; ack -> addr 0x00400004.
//  T2: addi rs=0,rt=8,imm=5 then lw rs=8,rt=9,imm=4 -> 0x20080005 @0x00400000, 0x8D090004 @0x00400004.
//  T3: sll rt=1,rd=2,shamt=4 with rs=31 -> 0x00011100; j target=0x100 -> 0x08000100.
//  T4: hold mem_ack=0 for 5 cycles -> mem_we, addr and data stable, in_ready=0; count increments only on the ack cycle.
//  T5: op_sel=12 -> err_illegal single pulse at N+1, no mem_we, mem_addr unchanged, in_ready=1.
//  T6: DEPTH=4, write 4 words -> full=1, in_ready=0, in_valid ignored; clear -> addr=BASE_ADDR, count=0, in_ready=1.

Source files
------------

// File: rtl/instruction_encoder.sv
// MIPS instruction encoder and program loader.
// Encodes field-level requests and streams the words into instruction memory.
module instruction_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 32'h00400000,
  parameter int unsigned          DEPTH     = 64,
  localparam int unsigned         CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err_illegal,
  output logic              full,
  output logic [CW-1:0]     word_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   enc;
  logic          legal;

  assign cnt_nxt    = cnt + CW'(1);
  assign in_ready   = (state == IDLE);
  assign mem_we     = (state == WRITE);
  assign full       = (state == FULL);
  assign word_count = cnt;

  // Field packing per opcode; unused fields stay zero.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (op_sel)
      4'd0:    enc = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
      4'd1:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd2:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd3:    enc = {6'h08, rs, rt, imm};
      4'd4:    enc = {6'h0C, rs, rt, imm};
      4'd5:    enc = {6'h2B, rs, rt, imm};
      4'd6:    enc = {6'h23, rs, rt, imm};
      4'd7:    enc = {6'h04, rs, rt, imm};
      4'd8:    enc = {6'h05, rs, rt, imm};
      4'd9:    enc = {6'h02, target};
      default: legal = 1'b0;
    endcase
  end

  // Loader FSM: accept in IDLE, hold the write until acked, park in FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 32'h0;
      err_illegal <= 1'b0;
      cnt         <= '0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            mem_addr <= BASE_ADDR;
            cnt      <= '0;
          end else if (in_valid) begin
            if (legal) begin
              mem_wdata <= enc;
              state     <= WRITE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + ADDR_W'(4);
            cnt      <= cnt_nxt;
            state    <= (cnt_nxt == CW'(DEPTH)) ? FULL : IDLE;
          end
        end
        FULL: begin
          if (clear) begin
            mem_addr <= BASE_ADDR;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
